muldiv_32: RTL
==============

# muldiv_32

Sequential signed multiply/divide unit for the Mini-SRC datapath. It sits beside the combinational ALU and feeds the ALU result stage. It computes the Mul and Div opcodes over multiple cycles and presents a 64-bit HI/LO result, which the ALU's HI/LO output mux forwards to the Z register pair. A start/busy/done handshake lets the control unit stall until the result is valid.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- clear  in  1  reset, asynchronous and active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- opcode  in  5  operation select: Mul = 5'b10000, Div = 5'b01111; any other value is ignored.
- A  in  32  multiplicand / dividend (signed).
- B  in  32  multiplier / divisor (signed).
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when C_out_HI/C_out_LO become valid.
- div_by_zero  out  1  high with done when Div had B = 0; held until the next accepted start.
- C_out_HI  out  32  Mul: product[63:32]; Div: remainder.
- C_out_LO  out  32  Mul: product[31:0]; Div: quotient.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - RUN: iterating.
  - DONE: result just completed.
- Accept rule: start=1 with opcode Mul or Div while in IDLE or DONE.
  - On accept, latch A, B and opcode; clear div_by_zero.
  - Next state is RUN, or DONE for the divide-by-zero case.
- start in RUN is ignored; latched operands are not disturbed.
- start with any other opcode is ignored; state and outputs are unchanged.
- Mul: radix-2 Booth, one iteration per cycle, 32 iterations.
  - Full signed 64-bit product; no overflow is possible.
- Div: non-restoring, one iteration per cycle, 32 iterations, on operand magnitudes, with a sign-fixup applied in the final iteration.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 yields quotient 0x80000000, remainder 0 (wrap, no flag).
- Div with B = 0: no iteration.
  - Result: C_out_LO = 0xFFFFFFFF, C_out_HI = A, div_by_zero = 1.
- RUN -> DONE after the last iteration. DONE -> IDLE the next cycle unless a new start is accepted, in which case DONE -> RUN.
- C_out_HI/C_out_LO update only on entry to DONE, and hold until the next completion. Intermediate partial values are never visible on the outputs.
- clear at any time, including mid-RUN:
  - state = IDLE;
  - busy, done, div_by_zero = 0;
  - C_out_HI, C_out_LO = 0;
  - the internal iteration counter and working registers = 0.
  - The in-flight operation is discarded.

## Timing
- Cycle N below is the rising edge at which start is accepted.
- Normal Mul or Div:
  - busy = 1 in cycles N+1 .. N+32;
  - done = 1 and results valid in cycle N+33, with busy = 0.
- Divide-by-zero: busy never asserts; done = 1 in cycle N+1.
- Back-to-back: start accepted in the done cycle (cycle D) gives busy from D+1. Minimum issue interval is 33 cycles.
- busy and done are never high together.
- All outputs are registered; there is no combinational path from the inputs to any output.

## Configuration
- BOOTH_RADIX4_EN:
  - Defined: Mul uses radix-4 Booth (two bits per cycle, 16 iterations). busy is high N+1 .. N+16 and done asserts at N+17.
  - Undefined: radix-2 as specified above.
- Div latency and all results are identical in both builds.

## Structure
- Shared package mini_src_pkg holds:
  - opcode constants (Mul, Div, plus the existing ALU opcodes);
  - the FSM state typedef (IDLE, RUN, DONE);
  - WIDTH and the iteration-count constants (32, or 16 for radix-4).
- One combinational sub-module, muldiv_step, performs a single iteration:
  - Mul: Booth recode and add/subtract/shift of the partial product.
  - Div: add/subtract and shift of the partial remainder.
  - The top level owns the FSM, counter, operand latches and output registers.

## Test plan
- Mul A = 7, B = -3 -> C_out_HI = 0xFFFFFFFF, C_out_LO = 0xFFFFFFEB; done at N+33 (N+17 with BOOTH_RADIX4_EN).
- Mul A = B = 0x80000000 -> C_out_HI = 0x40000000, C_out_LO = 0x00000000.
- Div A = -17, B = 5 -> C_out_LO = 0xFFFFFFFD, C_out_HI = 0xFFFFFFFE; done at N+33; div_by_zero = 0.
- Div A = 10, B = 0 -> done at N+1, div_by_zero = 1, C_out_LO = 0xFFFFFFFF, C_out_HI = 0x0000000A; busy never high.
- Mul in flight, start with new operands at N+5 -> ignored; the original product appears at N+33.
- clear asserted at N+10 of a Div -> outputs, busy and done go to 0 immediately. A subsequent Div 100/7 gives LO = 14, HI = 2, 33 cycles after its own start.

Source files
------------

// File: rtl/mini_src_pkg.sv
// ============================================================================
// Module   : mini_src_pkg
// Purpose  : Shared Mini-SRC constants: ALU opcodes, mul/div FSM states and
//            iteration counts. BOOTH_RADIX4_EN selects the radix-4 Mul count.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mini_src_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef BOOTH_RADIX4_EN
  localparam int MUL_ITER = 16;
`else
  localparam int MUL_ITER = 32;
`endif
  localparam int DIV_ITER = 32;

endpackage

`default_nettype wire

// File: rtl/muldiv_32_if.sv
// ============================================================================
// Module   : muldiv_32_if
// Purpose  : start/busy/done request and HI/LO result bundle of muldiv_32.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface muldiv_32_if #(
  parameter int WIDTH = mini_src_pkg::WIDTH
) ();

  logic             start;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] C_out_HI;
  logic [WIDTH-1:0] C_out_LO;

  modport master (
    output start, opcode, A, B,
    input  busy, done, div_by_zero, C_out_HI, C_out_LO
  );

  modport slave (
    input  start, opcode, A, B,
    output busy, done, div_by_zero, C_out_HI, C_out_LO
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational Booth (Mul) or non-restoring (Div) iteration.
//            BOOTH_RADIX4_EN switches Mul to radix-4 recoding.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = mini_src_pkg::WIDTH
) (
  input  wire logic             is_div,
  input  wire logic             last,
  input  wire logic             quo_neg,
  input  wire logic             rem_neg,
  input  wire logic [WIDTH+1:0] hi_i,
  input  wire logic [WIDTH-1:0] lo_i,
  input  wire logic             x_i,
  input  wire logic [WIDTH:0]   m_i,
  output logic      [WIDTH+1:0] hi_o,
  output logic      [WIDTH-1:0] lo_o,
  output logic                  x_o
);

  localparam int HW = WIDTH + 2;

  logic signed [HW-1:0] mx;
  logic signed [HW-1:0] sum;
  logic signed [HW-1:0] r_sh;
  logic signed [HW-1:0] r_new;
  logic signed [HW-1:0] rem;
  logic [WIDTH-1:0]     q_nx;

  always_comb begin
    mx    = {m_i[WIDTH], m_i};
    sum   = '0;
    r_sh  = '0;
    r_new = '0;
    rem   = '0;
    q_nx  = '0;
    hi_o  = hi_i;
    lo_o  = lo_i;
    x_o   = x_i;
    if (is_div) begin
      // Partial remainder stays within 33 bits, so the top bit is only a sign copy.
      r_sh  = {hi_i[WIDTH:0], lo_i[WIDTH-1]};
      r_new = hi_i[HW-1] ? r_sh + mx : r_sh - mx;
      q_nx  = {lo_i[WIDTH-2:0], ~r_new[HW-1]};
      hi_o  = r_new;
      lo_o  = q_nx;
      x_o   = 1'b0;
      if (last) begin
        rem  = r_new[HW-1] ? r_new + mx : r_new;
        hi_o = rem_neg ? -rem : rem;
        lo_o = quo_neg ? -q_nx : q_nx;
      end
    end else begin
`ifdef BOOTH_RADIX4_EN
      unique case ({lo_i[1:0], x_i})
        3'b001, 3'b010: sum = hi_i + mx;
        3'b011:         sum = hi_i + (mx <<< 1);
        3'b100:         sum = hi_i - (mx <<< 1);
        3'b101, 3'b110: sum = hi_i - mx;
        default:        sum = hi_i;
      endcase
      hi_o = sum >>> 2;
      lo_o = {sum[1:0], lo_i[WIDTH-1:2]};
      x_o  = lo_i[1];
`else
      unique case ({lo_i[0], x_i})
        2'b01:   sum = hi_i + mx;
        2'b10:   sum = hi_i - mx;
        default: sum = hi_i;
      endcase
      hi_o = sum >>> 1;
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
      x_o  = lo_i[0];
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_32.sv
// ============================================================================
// Module   : muldiv_32
// Purpose  : Sequential signed Mul/Div unit with start/busy/done handshake and
//            registered HI/LO result. BOOTH_RADIX4_EN halves Mul latency.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_32 #(
  parameter int WIDTH = mini_src_pkg::WIDTH
) (
  input wire logic   clock,
  input wire logic   clear,
  muldiv_32_if.slave bus
);

  import mini_src_pkg::*;

  localparam int HW = WIDTH + 2;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITER);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_ITER);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               quo_neg_q, quo_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [HW-1:0]      hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               x_q, x_d;
  logic [WIDTH:0]     m_q, m_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   out_hi_q, out_hi_d;
  logic [WIDTH-1:0]   out_lo_q, out_lo_d;

  logic [HW-1:0]      step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic               step_x;

  wire logic             is_mul_req = (bus.opcode == OP_MUL);
  wire logic             is_div_req = (bus.opcode == OP_DIV);
  wire logic             accept     = bus.start && (is_mul_req || is_div_req) && (state_q != RUN);
  wire logic             last       = (cnt_q == (div_q ? DIV_LAST : MUL_LAST));
  wire logic [WIDTH-1:0] a_mag      = bus.A[WIDTH-1] ? -bus.A : bus.A;
  wire logic [WIDTH-1:0] b_mag      = bus.B[WIDTH-1] ? -bus.B : bus.B;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (div_q),
    .last    (last),
    .quo_neg (quo_neg_q),
    .rem_neg (rem_neg_q),
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .x_i     (x_q),
    .m_i     (m_q),
    .hi_o    (step_hi),
    .lo_o    (step_lo),
    .x_o     (step_x)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    x_d       = x_q;
    m_d       = m_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    out_hi_d  = out_hi_q;
    out_lo_d  = out_lo_q;
    unique case (state_q)
      RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        x_d   = step_x;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          out_hi_d = step_hi[WIDTH-1:0];
          out_lo_d = step_lo;
        end
      end
      default: begin
        state_d = IDLE;
        // Working registers are seeded on the accept edge so the first iteration runs next cycle.
        if (accept) begin
          div_d     = is_div_req;
          quo_neg_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
          rem_neg_d = bus.A[WIDTH-1];
          dbz_d     = 1'b0;
          cnt_d     = CNT_W'(1);
          hi_d      = '0;
          x_d       = 1'b0;
          state_d   = RUN;
          busy_d    = 1'b1;
          if (is_div_req) begin
            lo_d = a_mag;
            m_d  = {1'b0, b_mag};
            if (bus.B == '0) begin
              state_d  = DONE;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              dbz_d    = 1'b1;
              cnt_d    = '0;
              out_hi_d = bus.A;
              out_lo_d = '1;
            end
          end else begin
            lo_d = bus.B;
            m_d  = {bus.A[WIDTH-1], bus.A};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      x_q       <= 1'b0;
      m_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      out_hi_q  <= '0;
      out_lo_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      x_q       <= x_d;
      m_q       <= m_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      out_hi_q  <= out_hi_d;
      out_lo_q  <= out_lo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.C_out_HI    = out_hi_q;
  assign bus.C_out_LO    = out_lo_q;

endmodule

`default_nettype wire
